ref_clk_sel_ctrl: RTL and testbench

Sequential, parametrised controller for the reference-clock divider tap-select transmission gates. It accepts a tap-index request through a load strobe. It switches the one-hot tgate enables break-before-make: all gates open for a programmable dead time, then the new gate closes. It then holds busy for a settle window so downstream logic does not sample the divided clock while it is unstable. It sits between the slow-control register file and the divider tgate array and generalises the fixed 5-tap combinational decode.

---
 rtl/ref_clk_sel_ctrl_if.sv | 25 ++
 rtl/ref_clk_sel_ctrl.sv | 152 +++++++++++++++
 tb/tb_ref_clk_sel_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ref_clk_sel_ctrl_if.sv
// Tap-select request/status bundle between the slow-control register file (master)
// and the reference-clock divider tgate controller (slave).
`timescale 1ns/1ps
interface ref_clk_sel_ctrl_if #(
    parameter int N_TAPS = 5,
    parameter int SEL_W  = $clog2(N_TAPS)
);
    logic [SEL_W-1:0]  sel_idx;
    logic              sel_load;
    logic [N_TAPS-1:0] tgate_control;
    logic [SEL_W-1:0]  cur_idx;
    logic              busy;
    logic              done;
    logic              sel_err;

    modport master (
        output sel_idx, sel_load,
        input  tgate_control, cur_idx, busy, done, sel_err
    );

    modport slave (
        input  sel_idx, sel_load,
        output tgate_control, cur_idx, busy, done, sel_err
    );
endinterface

// File: rtl/ref_clk_sel_ctrl.sv
// Break-before-make tap selector for the reference-clock divider tgates: load -> BREAK
// (all gates open DEAD_CYCLES) -> SETTLE (SETTLE_CYCLES) -> done; loads while busy queue one deep.
`timescale 1ns/1ps
module ref_clk_sel_ctrl #(
    parameter int N_TAPS        = 5,
    parameter int SEL_W         = $clog2(N_TAPS),
    parameter int DEFAULT_IDX   = 1,
    parameter int DEAD_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rstn,
    inout  wire                 VDD,
    inout  wire                 VSS,
    ref_clk_sel_ctrl_if.slave   ctl
);

    localparam int MAX_CYC = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [SEL_W-1:0]  DEF_SEL  = SEL_W'(DEFAULT_IDX);
    localparam logic [N_TAPS-1:0] DEF_GATE = N_TAPS'(1) << DEFAULT_IDX;
    localparam logic [CNT_W-1:0]  DEAD_LD  = CNT_W'(DEAD_CYCLES);
    localparam logic [CNT_W-1:0]  SETL_LD  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BREAK  = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    function automatic logic [N_TAPS-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_TAPS'(1) << idx;
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  cur_q, cur_d;
    logic [N_TAPS-1:0] gate_q, gate_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              pend_vld_q, pend_vld_d;
    logic [SEL_W-1:0]  pend_idx_q, pend_idx_d;

    logic              req_oor;
    logic [SEL_W-1:0]  req_idx;
    logic              take;
    logic [SEL_W-1:0]  take_idx;

    logic unused_pwr;
    assign unused_pwr = VDD ^ VSS;

    // Out-of-range requests fall back to the default tap.
    assign req_oor = ({1'b0, ctl.sel_idx} >= (SEL_W+1)'(N_TAPS));
    assign req_idx = req_oor ? DEF_SEL : ctl.sel_idx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_q      <= DEF_SEL;
            gate_q     <= DEF_GATE;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            gate_q     <= gate_d;
            done_q     <= done_d;
            err_q      <= err_d;
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        gate_d     = gate_q;
        done_d     = 1'b0;
        err_d      = err_q | (ctl.sel_load & req_oor);
        pend_vld_d = pend_vld_q;
        pend_idx_d = pend_idx_q;
        take       = 1'b0;
        take_idx   = cur_q;

        case (state_q)
            ST_IDLE: begin
                take     = ctl.sel_load;
                take_idx = req_idx;
            end
            ST_BREAK: begin
                if (ctl.sel_load) begin
                    pend_vld_d = 1'b1;
                    pend_idx_d = req_idx;
                end
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETL_LD;
                    gate_d  = onehot(cur_q);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q <= CNT_ONE) begin
                    // A load arriving on the exit cycle is newer than the queued one.
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                    pend_vld_d = 1'b0;
                    take       = ctl.sel_load | pend_vld_q;
                    take_idx   = ctl.sel_load ? req_idx : pend_idx_q;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (ctl.sel_load) begin
                        pend_vld_d = 1'b1;
                        pend_idx_d = req_idx;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gate_d  = onehot(cur_q);
            end
        endcase

        if (take) begin
            if (take_idx == cur_q) begin
                done_d = 1'b1;
            end else begin
                state_d = ST_BREAK;
                gate_d  = '0;
                cur_d   = take_idx;
                cnt_d   = DEAD_LD;
            end
        end
    end

    always_comb begin
        ctl.tgate_control = gate_q;
        ctl.cur_idx       = cur_q;
        ctl.busy          = (state_q != ST_IDLE);
        ctl.done          = done_q;
        ctl.sel_err       = err_q;
    end

endmodule

// File: tb/tb_ref_clk_sel_ctrl.sv
// Directed bench for ref_clk_sel_ctrl: reset, same-index, switch timing, pending queue,
// out-of-range fallback and async reset mid-switch, with a per-cycle one-hot monitor.
`timescale 1ns/1ps
module tb_ref_clk_sel_ctrl;
    localparam int N_TAPS = 5;
    localparam int SEL_W  = 3;

    logic clk = 1'b0;
    logic rstn;
    wire  vdd = 1'b1;
    wire  vss = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ref_clk_sel_ctrl_if #(.N_TAPS(N_TAPS), .SEL_W(SEL_W)) bus();

    ref_clk_sel_ctrl #(
        .N_TAPS(N_TAPS), .SEL_W(SEL_W), .DEFAULT_IDX(1),
        .DEAD_CYCLES(4), .SETTLE_CYCLES(8)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .VDD  (vdd),
        .VSS  (vss),
        .ctl  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("onehot0", 32'($onehot0(bus.tgate_control)), 32'd1);
    end

    // Drive one cycle of stimulus, advance to just after the next rising edge.
    task automatic step(input logic ld, input logic [SEL_W-1:0] idx);
        bus.sel_load = ld;
        bus.sel_idx  = idx;
        @(posedge clk);
        #1;
        bus.sel_load = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int n, input logic [4:0] tg,
                              input logic [2:0] cur, input logic busy, input logic done);
        chk($sformatf("%s.tg@%0d", tag, n),   32'(bus.tgate_control), 32'(tg));
        chk($sformatf("%s.cur@%0d", tag, n),  32'(bus.cur_idx),       32'(cur));
        chk($sformatf("%s.busy@%0d", tag, n), 32'(bus.busy),          32'(busy));
        chk($sformatf("%s.done@%0d", tag, n), 32'(bus.done),          32'(done));
    endtask

    // One switch from idle: load at cycle 0, gates open 1..4, new gate 5..12, done at 13.
    task automatic single_switch(input string tag, input logic [2:0] idx, input logic [2:0] tgt);
        for (int n = 1; n <= 14; n++) begin
            if (n == 1) step(1'b1, idx);
            else        step(1'b0, '0);
            expect_out(tag, n, (n <= 4) ? 5'b0 : 5'(1 << tgt), tgt, n <= 12, n == 13);
        end
    endtask

    // First switch to mid_t, extra loads at cycles b_cyc and c_cyc; chained switch to fin_t
    // begins with BREAK at cycle 13 and completes with done at cycle 25.
    task automatic chain(input string tag, input logic [2:0] a, input int b_cyc, input logic [2:0] b,
                         input int c_cyc, input logic [2:0] c,
                         input logic [2:0] mid_t, input logic [2:0] fin_t);
        logic [4:0] tg;
        for (int n = 1; n <= 26; n++) begin
            if (n == 1)              step(1'b1, a);
            else if (n == b_cyc + 1) step(1'b1, b);
            else if (n == c_cyc + 1) step(1'b1, c);
            else                     step(1'b0, '0);
            if (n <= 4)       tg = 5'b0;
            else if (n <= 12) tg = 5'(1 << mid_t);
            else if (n <= 16) tg = 5'b0;
            else              tg = 5'(1 << fin_t);
            expect_out(tag, n, tg, (n <= 12) ? mid_t : fin_t, n <= 24, (n == 13) || (n == 25));
        end
    endtask

    initial begin
        bus.sel_load = 1'b0;
        bus.sel_idx  = '0;
        rstn         = 1'b0;

        #12;
        expect_out("rst", 0, 5'b00010, 3'd1, 1'b0, 1'b0);
        chk("rst.err", 32'(bus.sel_err), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step(1'b0, '0);
        expect_out("rel", 1, 5'b00010, 3'd1, 1'b0, 1'b0);

        step(1'b1, 3'd1);
        expect_out("same", 1, 5'b00010, 3'd1, 1'b0, 1'b1);
        step(1'b0, '0);
        expect_out("same", 2, 5'b00010, 3'd1, 1'b0, 1'b0);

        single_switch("basic", 3'd4, 3'd4);

        chain("pend", 3'd3, 6, 3'd0, 8, 3'd2, 3'd3, 3'd2);
        chain("exitwin", 3'd4, 7, 3'd0, 12, 3'd3, 3'd4, 3'd3);

        chk("oor.err_pre", 32'(bus.sel_err), 32'd0);
        single_switch("oor", 3'd6, 3'd1);
        chk("oor.err_post", 32'(bus.sel_err), 32'd1);
        step(1'b0, '0);
        chk("oor.err_sticky", 32'(bus.sel_err), 32'd1);

        step(1'b1, 3'd4);
        expect_out("arst", 1, 5'b00000, 3'd4, 1'b1, 1'b0);
        step(1'b1, 3'd0);
        #3;
        rstn = 1'b0;
        #1;
        expect_out("arst", 2, 5'b00010, 3'd1, 1'b0, 1'b0);
        chk("arst.err", 32'(bus.sel_err), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            step(1'b0, '0);
            expect_out("postrst", n, 5'b00010, 3'd1, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
